// File: rtl/lrc_ctrl_pkg.sv
// rtl/lrc_ctrl_pkg.sv - shared state type, constants and config rule for the LRC frame sequencer
//
// Purpose : common definitions imported by lrc_frame_sequencer and lrc_xy_counter.
// Contents: lrc_state_e    - frame sequencer states
//           LRC_MAX_RANGE  - column/align buffer depth, upper bound for the disparity range
//           LRC_TO_W       - default drain timeout counter width
//           timeout_term() - terminal value of a drain timeout counter of a given width
//           cfg_valid()    - frame configuration acceptance rule
package lrc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } lrc_state_e;

   localparam int unsigned LRC_MAX_RANGE = 270;
   localparam int unsigned LRC_TO_W      = 16;

   // All-ones value of a to_w-bit counter.
   function automatic int unsigned timeout_term(input int unsigned to_w);
      return (32'd1 << to_w) - 32'd1;
   endfunction

   // A frame needs at least two columns and one row, and the disparity search
   // must fit both inside the buffers and inside the image width.
   function automatic logic cfg_valid(input int unsigned width,
                                      input int unsigned height,
                                      input int unsigned rng,
                                      input int unsigned max_rng);
      return (width >= 2) && (height >= 1) && (rng >= 1) &&
             (rng <= max_rng) && (rng < width);
   endfunction

endpackage

// File: rtl/lrc_xy_counter.sv
// rtl/lrc_xy_counter.sv - raster x/y pixel counter with wrap limits
//
// Purpose: counts pixels in raster order; x wraps at x_max_i and then y advances.
// Ports  : clk_i    - clock
//          rst_ni   - asynchronous active-low reset
//          clr_i    - synchronous clear to (0,0), wins over en_i
//          en_i     - advance by one pixel
//          x_max_i  - last column index (width-1)
//          y_max_i  - last row index (height-1)
//          x_o, y_o - current pixel coordinate
//          last_o   - current coordinate is (x_max_i, y_max_i)
module lrc_xy_counter
   import lrc_ctrl_pkg::*;
#(
   parameter int XW = 11,
   parameter int YW = 11
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [XW-1:0] x_max_i,
   input  logic [YW-1:0] y_max_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          last_o
);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          x_wrap;
   logic          y_wrap;

   assign x_wrap = (x_q == x_max_i);
   assign y_wrap = (y_q == y_max_i);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i) begin
         if (x_wrap) begin
            x_d = '0;
            y_d = y_wrap ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = x_wrap && y_wrap;

endmodule

// File: rtl/lrc_frame_sequencer.sv
// rtl/lrc_frame_sequencer.sv - frame-level controller for the windowed LRC check datapath
//
// Purpose: latches and validates a per-frame configuration, gates the L/R disparity
//          valid strobes and the datapath clock enable under downstream back-pressure,
//          tracks output pixel coordinates and reports frame completion or timeout.
// Ports  : clk, rst (async active-low)
//          start, cfg_img_width, cfg_img_height, cfg_range, cfg_check_th, cfg_sel_col
//                                   - frame request and requested configuration
//          valid_L_in, valid_R_in   - raw disparity valids
//          valid_lrc_in             - datapath result valid
//          out_ready                - downstream accepts a result this cycle
//          img_width, range, check_th, sel_col - shadow configuration to the datapath
//          clken                    - datapath clock enable
//          valid_final_L/R          - gated disparity valids
//          x_out, y_out, eof_out    - coordinate and end-of-frame of the current result beat
//          busy, done               - frame in progress / one-cycle completion pulse
//          err_cfg, err_timeout     - sticky: last start rejected / last frame timed out
module lrc_frame_sequencer
   import lrc_ctrl_pkg::*;
#(
   parameter int          WW        = 11,
   parameter int          HW        = 11,
   parameter int          RW        = 9,
   parameter int          TW        = 18,
   parameter int unsigned MAX_RANGE = LRC_MAX_RANGE,
   parameter int          TO_W      = LRC_TO_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [WW-1:0] cfg_img_width,
   input  logic [HW-1:0] cfg_img_height,
   input  logic [RW-1:0] cfg_range,
   input  logic [TW-1:0] cfg_check_th,
   input  logic          cfg_sel_col,
   input  logic          valid_L_in,
   input  logic          valid_R_in,
   input  logic          valid_lrc_in,
   input  logic          out_ready,
   output logic [WW-1:0] img_width,
   output logic [RW-1:0] range,
   output logic [TW-1:0] check_th,
   output logic          sel_col,
   output logic          clken,
   output logic          valid_final_L,
   output logic          valid_final_R,
   output logic [WW-1:0] x_out,
   output logic [HW-1:0] y_out,
   output logic          eof_out,
   output logic          busy,
   output logic          done,
   output logic          err_cfg,
   output logic          err_timeout
);

   // Last idle count before the counter would reach its all-ones terminal value.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_term(TO_W) - 32'd1);

   lrc_state_e    state_q;
   logic [WW-1:0] img_width_q;
   logic [HW-1:0] img_height_q;
   logic [RW-1:0] range_q;
   logic [TW-1:0] check_th_q;
   logic          sel_col_q;
   logic [WW-1:0] w_max_q;
   logic [HW-1:0] h_max_q;
   logic          l_full_q, l_full_d;
   logic          r_full_q, r_full_d;
   logic [TO_W-1:0] to_cnt_q;
   logic          busy_q;
   logic          done_q;
   logic          err_cfg_q;
   logic          err_timeout_q;

   logic          cfg_ok;
   logic          in_frame;
   logic          clken_w;
   logic          vfl_w, vfr_w;
   logic          out_en;
   logic          eof_w;
   logic          cnt_clr;

   logic [WW-1:0] l_x, r_x, o_x;
   logic [HW-1:0] l_y, r_y, o_y;
   logic          l_last, r_last, o_last;
   logic          unused_lr_xy;

   assign cfg_ok = cfg_valid(32'(img_width_q), 32'(img_height_q), 32'(range_q), MAX_RANGE);

   assign in_frame = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign clken_w  = in_frame && out_ready;
   assign vfl_w    = (state_q == ST_RUN) && valid_L_in && clken_w && !l_full_q;
   assign vfr_w    = (state_q == ST_RUN) && valid_R_in && clken_w && !r_full_q;
   assign out_en   = in_frame && valid_lrc_in;
   assign eof_w    = out_en && o_last;
   assign cnt_clr  = (state_q == ST_CHECK) && cfg_ok;

   // Full flags as they will be after this cycle, so RUN can leave on the
   // same edge that accepts the final pixel of the slower side.
   assign l_full_d = l_full_q || (vfl_w && l_last);
   assign r_full_d = r_full_q || (vfr_w && r_last);

   lrc_xy_counter #(.XW(WW), .YW(HW)) u_cnt_l (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (cnt_clr),
      .en_i    (vfl_w),
      .x_max_i (w_max_q),
      .y_max_i (h_max_q),
      .x_o     (l_x),
      .y_o     (l_y),
      .last_o  (l_last)
   );

   lrc_xy_counter #(.XW(WW), .YW(HW)) u_cnt_r (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (cnt_clr),
      .en_i    (vfr_w),
      .x_max_i (w_max_q),
      .y_max_i (h_max_q),
      .x_o     (r_x),
      .y_o     (r_y),
      .last_o  (r_last)
   );

   lrc_xy_counter #(.XW(WW), .YW(HW)) u_cnt_o (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (cnt_clr),
      .en_i    (out_en),
      .x_max_i (w_max_q),
      .y_max_i (h_max_q),
      .x_o     (o_x),
      .y_o     (o_y),
      .last_o  (o_last)
   );

   // Input-side counters matter only through their last flags.
   assign unused_lr_xy = ^{l_x, l_y, r_x, r_y};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         img_width_q   <= '0;
         img_height_q  <= '0;
         range_q       <= '0;
         check_th_q    <= '0;
         sel_col_q     <= 1'b0;
         w_max_q       <= '0;
         h_max_q       <= '0;
         l_full_q      <= 1'b0;
         r_full_q      <= 1'b0;
         to_cnt_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_cfg_q     <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  img_width_q   <= cfg_img_width;
                  img_height_q  <= cfg_img_height;
                  range_q       <= cfg_range;
                  check_th_q    <= cfg_check_th;
                  sel_col_q     <= cfg_sel_col;
                  err_cfg_q     <= 1'b0;
                  err_timeout_q <= 1'b0;
                  busy_q        <= 1'b1;
                  state_q       <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (cfg_ok) begin
                  w_max_q  <= img_width_q - WW'(1);
                  h_max_q  <= img_height_q - HW'(1);
                  l_full_q <= 1'b0;
                  r_full_q <= 1'b0;
                  to_cnt_q <= '0;
                  state_q  <= ST_RUN;
               end else begin
                  err_cfg_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            ST_RUN: begin
               l_full_q <= l_full_d;
               r_full_q <= r_full_d;
               if (eof_w) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (l_full_d && r_full_d) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (eof_w) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (valid_lrc_in) begin
                  to_cnt_q <= '0;
               end else if (to_cnt_q == TO_LAST) begin
                  to_cnt_q      <= to_cnt_q + TO_W'(1);
                  err_timeout_q <= 1'b1;
                  busy_q        <= 1'b0;
                  done_q        <= 1'b1;
                  state_q       <= ST_DONE;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign img_width     = img_width_q;
   assign range         = range_q;
   assign check_th      = check_th_q;
   assign sel_col       = sel_col_q;
   assign clken         = clken_w;
   assign valid_final_L = vfl_w;
   assign valid_final_R = vfr_w;
   assign x_out         = o_x;
   assign y_out         = o_y;
   assign eof_out       = eof_w;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_cfg       = err_cfg_q;
   assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_lrc_frame_sequencer.sv
// tb/tb_lrc_frame_sequencer.sv - randomized self-checking bench for lrc_frame_sequencer
module tb_lrc_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [10:0] cfg_img_width = '0;
   logic [10:0] cfg_img_height = '0;
   logic [8:0]  cfg_range = '0;
   logic [17:0] cfg_check_th = '0;
   logic        cfg_sel_col = 1'b0;
   logic        valid_L_in = 1'b0;
   logic        valid_R_in = 1'b0;
   logic        valid_lrc_in = 1'b0;
   logic        out_ready = 1'b0;
   logic [10:0] img_width;
   logic [8:0]  range;
   logic [17:0] check_th;
   logic        sel_col;
   logic        clken;
   logic        valid_final_L;
   logic        valid_final_R;
   logic [10:0] x_out;
   logic [10:0] y_out;
   logic        eof_out;
   logic        busy;
   logic        done;
   logic        err_cfg;
   logic        err_timeout;

   int n_chk = 0;
   int n_pass = 0;
   int vfl_cnt = 0;
   int vfr_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   lrc_frame_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .cfg_img_width  (cfg_img_width),
      .cfg_img_height (cfg_img_height),
      .cfg_range      (cfg_range),
      .cfg_check_th   (cfg_check_th),
      .cfg_sel_col    (cfg_sel_col),
      .valid_L_in     (valid_L_in),
      .valid_R_in     (valid_R_in),
      .valid_lrc_in   (valid_lrc_in),
      .out_ready      (out_ready),
      .img_width      (img_width),
      .range          (range),
      .check_th       (check_th),
      .sel_col        (sel_col),
      .clken          (clken),
      .valid_final_L  (valid_final_L),
      .valid_final_R  (valid_final_R),
      .x_out          (x_out),
      .y_out          (y_out),
      .eof_out        (eof_out),
      .busy           (busy),
      .done           (done),
      .err_cfg        (err_cfg),
      .err_timeout    (err_timeout)
   );

   always @(negedge clk) begin
      if (valid_final_L) vfl_cnt++;
      if (valid_final_R) vfr_cnt++;
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic bit cfg_rule(input int w, input int h, input int rng);
      return (w >= 2) && (h >= 1) && (rng >= 1) && (rng <= 270) && (rng < w);
   endfunction

   // Called just after a rising edge; returns just after the edge that enters RUN
   // (or returns to IDLE for a rejected configuration).
   task automatic start_frame(input int w, input int h, input int rng,
                              input logic [17:0] th, input logic sc);
      cfg_img_width  = 11'(w);
      cfg_img_height = 11'(h);
      cfg_range      = 9'(rng);
      cfg_check_th   = th;
      cfg_sel_col    = sc;
      start          = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input int w, input int h, input int rng, input int rdy_mode,
                            input int p_l, input int p_r, input bit inject, input bit to_mode);
      int n, acc_l, acc_r, beat, cyc, l0, r0, d0;
      bit exp_l, exp_r, rdy_t, seen;
      logic [17:0] th;
      logic sc;
      n  = w * h;
      th = 18'($urandom);
      sc = 1'($urandom);
      l0 = vfl_cnt; r0 = vfr_cnt; d0 = done_cnt;
      start_frame(w, h, rng, th, sc);
      chk("err_cfg_clear", 32'(err_cfg), 32'd0);
      chk("err_to_clear", 32'(err_timeout), 32'd0);
      chk("busy_run", 32'(busy), 32'd1);

      acc_l = 0; acc_r = 0; cyc = 0; rdy_t = 1'b1;
      while ((acc_l < n || acc_r < n) && cyc < 4000) begin
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = rdy_t;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         rdy_t = ~rdy_t;
         valid_L_in = ($urandom_range(0, 99) < p_l);
         valid_R_in = ($urandom_range(0, 99) < p_r);
         start = inject && (cyc == 3);
         if (start) begin
            cfg_img_width = 11'($urandom);
            cfg_range     = 9'($urandom);
            cfg_check_th  = 18'($urandom);
            cfg_sel_col   = ~sc;
         end
         @(negedge clk);
         exp_l = valid_L_in && out_ready && (acc_l < n);
         exp_r = valid_R_in && out_ready && (acc_r < n);
         chk("vfl_run", 32'(valid_final_L), 32'(exp_l));
         chk("vfr_run", 32'(valid_final_R), 32'(exp_r));
         chk("clken_run", 32'(clken), 32'(out_ready));
         acc_l += int'(exp_l);
         acc_r += int'(exp_r);
         cyc++;
         @(posedge clk); #1;
      end
      start = 1'b0; valid_L_in = 1'b0; valid_R_in = 1'b0;
      chk("run_fill", 32'(acc_l + acc_r), 32'(2 * n));

      if (!to_mode) begin
         chk("busy_drain", 32'(busy), 32'd1);
         beat = 0; cyc = 0;
         while (beat < n && cyc < 4000) begin
            valid_lrc_in = 1'($urandom_range(0, 1));
            out_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("clken_drain", 32'(clken), 32'(out_ready));
            chk("vfl_drain", 32'(valid_final_L), 32'd0);
            if (valid_lrc_in) begin
               chk("x_out", 32'(x_out), 32'(beat % w));
               chk("y_out", 32'(y_out), 32'(beat / w));
               chk("eof_out", 32'(eof_out), 32'(beat == n - 1));
               beat++;
            end else begin
               chk("eof_idle", 32'(eof_out), 32'd0);
            end
            cyc++;
            @(posedge clk); #1;
         end
         valid_lrc_in = 1'b0; out_ready = 1'b1;
         chk("drain_beats", 32'(beat), 32'(n));
         @(negedge clk);
      end else begin
         out_ready = 1'b1; valid_lrc_in = 1'b0;
         cyc = 0; seen = 1'b0;
         while (!seen && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            seen = done;
            if (!seen) begin
               @(posedge clk); #1;
            end
         end
         chk("timeout_cycles", 32'(cyc), 32'd65536);
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("clken_done", 32'(clken), 32'd0);
      chk("err_timeout", 32'(err_timeout), 32'(to_mode));
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("vfl_total", 32'(vfl_cnt - l0), 32'(n));
      chk("vfr_total", 32'(vfr_cnt - r0), 32'(n));
      chk("shadow_width", 32'(img_width), 32'(w));
      chk("shadow_range", 32'(range), 32'(rng));
      chk("shadow_th", 32'(check_th), 32'(th));
      chk("shadow_sel", 32'(sel_col), 32'(sc));
   endtask

   task automatic bad_cfg(input int w, input int h, input int rng);
      int d0;
      d0 = done_cnt;
      out_ready = 1'b1;
      start_frame(w, h, rng, 18'($urandom), 1'($urandom));
      @(negedge clk);
      chk("err_cfg", 32'(err_cfg), 32'(!cfg_rule(w, h, rng)));
      chk("busy_bad", 32'(busy), 32'd0);
      chk("clken_bad", 32'(clken), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_bad", 32'(done_cnt - d0), 32'd0);
   endtask

   initial begin
      int w, h, rng, d0;
      rst = 1'b0;
      out_ready = 1'b1; valid_L_in = 1'b1; valid_R_in = 1'b1; valid_lrc_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_clken", 32'(clken), 32'd0);
      chk("rst_vfl", 32'(valid_final_L), 32'd0);
      chk("rst_vfr", 32'(valid_final_R), 32'd0);
      chk("rst_eof", 32'(eof_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err_cfg", 32'(err_cfg), 32'd0);
      chk("rst_err_to", 32'(err_timeout), 32'd0);
      chk("rst_width", 32'(img_width), 32'd0);
      chk("rst_x", 32'(x_out), 32'd0);
      valid_L_in = 1'b0; valid_R_in = 1'b0; valid_lrc_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_frame(8, 4, 4, 0, 100, 100, 1'b0, 1'b0);
      run_frame(8, 4, 4, 1, 100, 100, 1'b0, 1'b0);
      bad_cfg(8, 4, 8);
      run_frame(8, 4, 4, 2, 100, 60, 1'b1, 1'b0);
      run_frame(300, 1, 270, 2, 70, 70, 1'b0, 1'b0);
      bad_cfg(300, 1, 271);
      bad_cfg(1, 4, 0);
      bad_cfg(2, 0, 1);
      bad_cfg(8, 4, 0);
      run_frame(2, 1, 1, 0, 100, 100, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         w   = int'($urandom_range(0, 12));
         h   = int'($urandom_range(0, 5));
         rng = int'($urandom_range(0, 12));
         if (cfg_rule(w, h, rng))
            run_frame(w, h, rng, 2, int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
                      1'($urandom), 1'b0);
         else
            bad_cfg(w, h, rng);
      end

      start_frame(8, 4, 4, 18'h1234, 1'b1);
      valid_L_in = 1'b1; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      d0 = done_cnt;
      rst = 1'b0;
      #1;
      chk("mid_rst_clken", 32'(clken), 32'd0);
      chk("mid_rst_vfl", 32'(valid_final_L), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_width", 32'(img_width), 32'd0);
      chk("mid_rst_range", 32'(range), 32'd0);
      chk("mid_rst_th", 32'(check_th), 32'd0);
      chk("mid_rst_sel", 32'(sel_col), 32'd0);
      @(posedge clk); #1;
      valid_L_in = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_done", 32'(done_cnt - d0), 32'd0);
      run_frame(8, 4, 4, 0, 100, 100, 1'b0, 1'b0);

      run_frame(2, 1, 1, 0, 100, 100, 1'b0, 1'b1);
      run_frame(4, 2, 1, 2, 80, 80, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lrc_frame_sequencer.md
Name: lrc_frame_sequencer

Overview:
- Frame-level controller for the windowed left-right consistency check datapath (right/left disparity buffers, column/align buffers, check engine).
- Latches a per-frame configuration into shadow registers and validates it.
- Gates the L/R disparity valid strobes and the datapath clock enable, with downstream back-pressure.
- Tracks output pixel coordinates, and signals frame completion or timeout.

Parameters:
- WW, 11, image width/column counter bits (matches datapath img_width)
- HW, 11, image height/row counter bits
- RW, 9, disparity range bits
- TW, 18, check threshold bits (10 integer + 8 fraction)
- MAX_RANGE, 270, column/align buffer depth; upper bound for range
- TO_W, 16, drain timeout counter bits

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start request, sampled in IDLE only
- cfg_img_width  in  WW  requested width
- cfg_img_height  in  HW  requested height
- cfg_range  in  RW  requested disparity range
- cfg_check_th  in  TW  requested threshold
- cfg_sel_col  in  1  requested column shape
- valid_L_in  in  1  raw left disparity valid
- valid_R_in  in  1  raw right disparity valid
- valid_lrc_in  in  1  datapath output valid (valid_final_lrc)
- out_ready  in  1  downstream can accept a result this cycle
- img_width  out  WW  shadow width to datapath
- range  out  RW  shadow range
- check_th  out  TW  shadow threshold
- sel_col  out  1  shadow column shape
- clken  out  1  datapath clock enable
- valid_final_L  out  1  gated left valid
- valid_final_R  out  1  gated right valid
- x_out  out  WW  column of current valid_lrc_in beat
- y_out  out  HW  row of current valid_lrc_in beat
- eof_out  out  1  current beat is the last pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle completion pulse
- err_cfg  out  1  sticky: last start rejected
- err_timeout  out  1  sticky: last frame ended by drain timeout

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs, shadow registers, counters and sticky flags cleared to 0. Reset asserted mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, CHECK, RUN, DRAIN, DONE.
- IDLE:
  - busy=0, clken=0.
  - start=1 latches all cfg_* into the shadow registers and moves to CHECK.
  - err_cfg and err_timeout clear on this start.
- CHECK (1 cycle):
  - Config is valid iff width>=2, height>=1, 1<=range<=MAX_RANGE and range<width.
  - Valid: clear the L, R and output counters; go to RUN.
  - Invalid: set err_cfg; return to IDLE; no done pulse.
- RUN:
  - busy=1.
  - clken = out_ready (combinational).
  - valid_final_L = valid_L_in & clken & !L_full; R is identical with its own flag.
  - L and R each have an x/y counter that advances on every gated valid.
  - L_full is set when pixel (width-1, height-1) is accepted; R_full likewise.
  - When both are full, go to DRAIN. Input beats arriving after full are dropped, not counted.
- DRAIN:
  - clken = out_ready; valid_final_L and valid_final_R are 0.
  - Timeout counter increments each cycle with no valid_lrc_in and resets on each beat.
  - If it reaches 2^TO_W-1: set err_timeout and go to DONE.
- Output counting (RUN and DRAIN):
  - Each valid_lrc_in increments x_out, wrapping at width-1 and then incrementing y_out.
  - eof_out = valid_lrc_in & x_out==width-1 & y_out==height-1.
  - A beat with eof_out moves the FSM to DONE (from RUN or DRAIN).
- DONE (1 cycle): done=1, busy=0, clken=0; then IDLE.
- start while not IDLE is ignored.
- Shadow registers hold their values from CHECK until the next accepted start; outputs are stable through the whole frame.
- Latency: the gated valids and clken are combinational from their inputs; state, counters and flags are registered with 1-cycle latency.
- Counter width rule: compare against width-1 and height-1 computed at CHECK; no multiplier.

Decomposition:
- Package lrc_ctrl_pkg holds:
  - the state enum (IDLE, CHECK, RUN, DRAIN, DONE)
  - MAX_RANGE
  - timeout terminal value
  - the config-validity function
- One natural sub-module, lrc_xy_counter: clear, enable, width/height limits; outputs x, y, last. Instantiated three times (L, R, output).

Test Plan:
- Nominal frame: width=8, height=4, range=4, out_ready=1; 32 L and 32 R valids, then 32 valid_lrc_in beats -> valid_final_L/valid_final_R each 32 pulses; eof_out on beat 32 with x_out=7, y_out=3; done pulse 1 cycle later; busy=0.
- Back-pressure: same frame with out_ready toggling 1/0 each cycle -> clken mirrors out_ready; no valid_final_* while out_ready=0; counts still 32/32/32; done asserted once.
- Bad config: range=8, width=8 -> err_cfg=1 two cycles after start; no clken, no done; then a valid start clears err_cfg.
- Overrun and ignored start: 40 L valids into an 8x4 frame plus start pulsed in RUN -> only 32 valid_final_L; config unchanged.
- Drain timeout: inputs complete, valid_lrc_in held 0 -> after 65535 idle cycles err_timeout=1 and done pulses.
- Reset mid-RUN after 10 pixels: rst=0 -> all outputs 0 immediately; after release the FSM is in IDLE and a new start runs a clean frame.
